// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: funct3 codes,
// FSM state encoding and the funct3 legality helper.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Unsigned sizes only exist for loads; 011/110/111 are never legal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load lane selection with sign/zero extension, and the misaligned/illegal flag.
module load_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_fmt,
  output logic        bad
);

  logic [31:0] lane;
  logic        misaligned;

  // Store side: enables shifted to the addressed lane, data copied to every lane.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    lane     = rdata >> {off, 3'b000};
    load_fmt = lane;
    case (funct3)
      F3_B:    load_fmt = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_fmt = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_fmt = {24'h0, lane[7:0]};
      F3_HU:   load_fmt = {16'h0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  // Halfwords need an even address, words a word-aligned one.
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    bad = misaligned | ~f3_legal(funct3, we);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer. Accepts one load/store from EX/MEM, runs
// the bus request/ready handshake with a wait-cycle timeout, and stalls the
// pipeline through memory_busy until the access has finished.
//
// Bus handshake: bus_req is high for exactly the BUS state and all bus_*
// request fields are stable while it is high. A transfer completes in the
// cycle where bus_req and bus_ready are both high; bus_rdata and bus_err are
// only looked at in that cycle. bus_ready outside BUS is ignored.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        memory_busy,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        store_done,
  output logic        misaligned_fault,
  output logic        bus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  state_dbg
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        mis_q;
  logic [31:0] load_data_q;

  logic        req;
  logic        accept;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic        sel_we;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_bad;

  // Stores win when both read and write are asserted.
  assign req = mem_read | mem_write;

  // In IDLE the aligner checks the incoming request; afterwards it formats
  // read data using the latched access attributes.
  assign sel_f3  = (state_q == ST_IDLE) ? funct3    : f3_q;
  assign sel_off = (state_q == ST_IDLE) ? addr[1:0] : off_q;
  assign sel_we  = (state_q == ST_IDLE) ? mem_write : we_q;

  load_store_align u_align (
    .funct3    (sel_f3),
    .off       (sel_off),
    .we        (sel_we),
    .wdata     (wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_fmt  (al_load),
    .bad       (al_bad)
  );

  // Next-state and stall decode.
  always_comb begin
    state_d     = state_q;
    memory_busy = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          memory_busy = 1'b1;
          if (al_bad) begin
            state_d = ST_FAULT;
          end else begin
            accept  = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        memory_busy = 1'b1;
        if (bus_ready) begin
          state_d = bus_err ? ST_FAULT : ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and wait counter; the counter only runs while waiting in BUS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_BUS && state_d == ST_BUS) ? cnt_q + CW'(1) : '0;
    end
  end

  // Access attributes latched at accept, fault cause, and the load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= mem_write;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= al_be;
        wdata_q <= al_wdata;
      end
      if (state_q == ST_IDLE && state_d == ST_FAULT) begin
        mis_q <= 1'b1;
      end else if (state_q == ST_BUS && state_d == ST_FAULT) begin
        mis_q <= 1'b0;
      end
      if (state_q == ST_BUS && bus_ready && !bus_err && !we_q) begin
        load_data_q <= al_load;
      end
    end
  end

  assign bus_req          = (state_q == ST_BUS);
  assign bus_we           = we_q;
  assign bus_addr         = addr_q;
  assign bus_be           = be_q;
  assign bus_wdata        = wdata_q;
  assign load_data        = load_data_q;
  assign load_valid       = (state_q == ST_DONE) & ~we_q;
  assign store_done       = (state_q == ST_DONE) & we_q;
  assign misaligned_fault = (state_q == ST_FAULT) & mis_q;
  assign bus_fault        = (state_q == ST_FAULT) & ~mis_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store sequencer between the EX/MEM pipeline register and the data-memory bus. It accepts one load or store per instruction, runs a multi-cycle request/ready handshake on the bus, and formats byte lanes for sub-word accesses. It drives `memory_busy` into the stall controller for as long as the access is outstanding, which freezes the front of the pipeline.

## Interface
- `TIMEOUT_CYCLES`, 16: number of bus wait cycles after which the access is abandoned with a bus fault.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `mem_read` in 1: the EX/MEM instruction is a load.
- `mem_write` in 1: the EX/MEM instruction is a store. If both `mem_read` and `mem_write` are set, the access is treated as a store.
- `funct3` in 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `memory_busy` out 1: stall request to the stall controller.
- `load_data` out 32: formatted, sign- or zero-extended load result.
- `load_valid` out 1: one-cycle pulse; `load_data` is valid in this cycle.
- `store_done` out 1: one-cycle pulse when a store completes.
- `misaligned_fault` out 1: one-cycle pulse for a misaligned access or illegal `funct3`.
- `bus_fault` out 1: one-cycle pulse on `bus_err` or timeout.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word-aligned address (`addr[31:2]`, 2'b00).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: store data replicated across byte lanes.
- `bus_ready` in 1: bus handshake completes this cycle.
- `bus_rdata` in 32: read data, valid when `bus_ready` is high.
- `bus_err` in 1: error response, valid when `bus_ready` is high.

## Operation
**State machine:** IDLE, BUS, DONE, FAULT.

**IDLE**
- A request is `mem_read | mem_write`.
- Request with a legal `funct3` and aligned address:
  - latch `we`, `funct3`, `addr[1:0]`, word address, `be` and replicated wdata;
  - go to BUS;
  - `memory_busy` = 1 combinationally in this same cycle.
- Request that is misaligned or has an illegal `funct3`:
  - go to FAULT; no bus activity;
  - `memory_busy` = 1 in this cycle.
- Misaligned means: H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
- Illegal `funct3`: 011, 110, 111, and any store `funct3` above 010.

**BUS**
- `bus_req` = 1; `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are held stable.
- `memory_busy` = 1.
- A wait counter increments on every cycle with `bus_ready` = 0.
- On `bus_ready`:
  - capture and format `bus_rdata`;
  - go to DONE if `bus_err` = 0, otherwise go to FAULT.
- When the counter reaches `TIMEOUT_CYCLES` - 1 with no `bus_ready`: go to FAULT.

**DONE**
- `memory_busy` = 0, so the pipeline advances this cycle.
- `load_valid` = 1 for loads; `store_done` = 1 for stores.
- Next state: IDLE.

**FAULT**
- `memory_busy` = 0.
- Pulse `misaligned_fault` or `bus_fault`, whichever caused the entry.
- Next state: IDLE.

**Byte-lane rules** (`off` = `addr[1:0]`)
- Store byte enables: SB `be` = 4'b0001 << `off`; SH `be` = 4'b0011 << `off`; SW `be` = 4'b1111.
- Store data: SB `wdata[7:0]` ×4; SH `wdata[15:0]` ×2; SW as is.
- Loads select the lane `rdata >> (8*off)`, then:
  - B: sign-extend bit 7;
  - H: sign-extend bit 15;
  - BU/HU: zero-extend.

**Requester contract**
- The requester holds its inputs stable while `memory_busy` = 1.
- DONE and FAULT always return to IDLE, so a held request is never re-issued.

## Timing
**Reset**
- State IDLE, wait counter 0.
- All outputs 0, including `bus_req`, `bus_be` and `load_data`.

**Latency**
- Cycle 0: IDLE accepts the request.
- Cycle 1: BUS.
- If `bus_ready` = 1 in cycle 1, DONE is in cycle 2.
- This gives a minimum of 2 stall cycles. Each wait cycle adds one.

**Handshake and outputs**
- `bus_req` is registered: it rises at the cycle-1 edge and falls at the edge after `bus_ready`.
- `load_data` is registered and holds its value until the next load completes.
- `bus_ready` is ignored outside BUS.

**Boundary cases**
- Timeout takes priority over nothing. `bus_ready` arriving in the same cycle the counter reaches its limit completes normally.
- `rst_n` low in any state returns to IDLE at that edge and drops `bus_req`. No pulse is emitted, and the abandoned access is not replayed.

## Structure
**Shared header `mem_defs.vh`**
- `funct3` localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- FSM state encodings: 2-bit.

**Sub-module `load_store_align` (combinational)**
- Inputs: `funct3`, `off`, `wdata`, `rdata`.
- Outputs: `be`, replicated wdata, formatted load data, `misaligned`/illegal flag.

**Top level:** FSM, wait counter, registers.

## Test plan
1. LW, `addr` 0x100, `bus_ready` in the first BUS cycle, `rdata` 0xDEADBEEF: `busy` high for 2 cycles, then `load_valid` with `load_data` 0xDEADBEEF.
2. LB `addr` 0x103, `rdata` 0x80FF_0000: `load_data` 0xFFFFFF80. LBU at the same address: 0x00000080. LHU at 0x102: 0x000080FF.
3. SB `addr` 0x201, `wdata` 0x000000AB: `bus_be` 4'b0010, `bus_wdata` 0xABABABAB, `bus_addr` 0x200, `store_done` pulse.
4. LH at `addr` 0x101: no `bus_req`, `misaligned_fault` pulse one cycle after the request, `busy` for 1 cycle only.
5. `bus_ready` held low, `TIMEOUT_CYCLES` = 4: `bus_fault` after 4 BUS cycles, `bus_req` drops. Separately, `bus_ready` with `bus_err` = 1: `bus_fault` and no `load_valid`.
6. `rst_n` asserted low during BUS wait: next edge state IDLE, `bus_req` = 0, no pulses. A new LW after reset completes normally.
